// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared core constants and the fetch FSM state encoding.
package inst_fetch_pkg;
    localparam int INST_WIDTH = 32;
    localparam int INST_MEM_ADDR = 9;
    localparam logic [INST_MEM_ADDR-1:0] INST_MEM_START = '0;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} fetch_state_e;
endpackage

// File: rtl/inst_fetch_fifo.sv
// fetch_fifo: circular instruction buffer with push/pop/flush and occupancy count.
module fetch_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = flush ? '0 : push ? (wr_ptr_q == PW'(DEPTH-1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = flush ? '0 : pop ? (rd_ptr_q == PW'(DEPTH-1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= din;
    end

    assign dout = count_q != '0 ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch engine with credit-limited reads into an output FIFO.
// Define INST_FETCH_REDIRECT_EN to enable redirect flushing; otherwise redirect is ignored.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [INST_MEM_ADDR-1:0] start_pc,
    input  logic                     stop,
    input  logic                     redirect,
    input  logic [INST_MEM_ADDR-1:0] redirect_pc,
    output logic                     imem_rd_en,
    output logic [INST_MEM_ADDR-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0]    imem_data,
    output logic [INST_WIDTH-1:0]    inst_out,
    output logic [INST_MEM_ADDR-1:0] inst_pc,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic                     busy
);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    fetch_state_e state_q, state_d;
    logic [INST_MEM_ADDR-1:0] pc_q, pc_d, flight_pc_q, flight_pc_d;
    logic flight_q, flight_d;
    logic flush, pop, push;
    logic [CW-1:0] count;
    logic [CW:0] occ;

`ifdef INST_FETCH_REDIRECT_EN
    assign flush = redirect && state_q != IDLE;
`else
    logic unused_redirect;
    assign flush = 1'b0;
    assign unused_redirect = ^{redirect, redirect_pc};
`endif

    // occ counts entries that will occupy the buffer after this cycle's pop, including the in-flight read
    always_comb begin
        pop = inst_valid && inst_ready;
        push = flight_q && !flush;
        occ = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(flight_q);
        imem_rd_en = state_q == RUN && !stop && !flush && occ < (CW+1)'(FIFO_DEPTH);
        imem_addr = pc_q;
        flight_d = imem_rd_en;
        flight_pc_d = pc_q;
        pc_d = (state_q == IDLE && start) ? start_pc
             : flush ? redirect_pc
             : imem_rd_en ? pc_q + 1'b1 : pc_q;
        state_d = flush ? (stop ? IDLE : RUN)
                : (state_q == IDLE && start) ? RUN
                : (state_q == RUN && stop) ? DRAIN
                : (state_q == DRAIN && occ == '0) ? IDLE : state_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q <= INST_MEM_START;
            flight_q <= 1'b0;
            flight_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            flight_q <= flight_d;
            flight_pc_q <= flight_pc_d;
        end
    end

    fetch_fifo #(.WIDTH(INST_MEM_ADDR + INST_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .flush(flush),
        .din({flight_pc_q, imem_data}),
        .dout({inst_pc, inst_out}),
        .count(count)
    );

    assign inst_valid = count != '0;
    assign busy = state_q != IDLE;
endmodule
